riscv_mc_controller: RTL and testbench
======================================

Name: riscv_mc_controller

Overview:
- Multicycle control unit sitting directly upstream of the ALU; sequences each instruction through a Moore FSM.
- Drives all datapath selects and write enables, and generates the 3-bit ALUControl consumed by the ALU.
- Consumes the ALU Zero flag to resolve branches.
- Supports lw, sw, R-type, I-type ALU, beq and jal.

Parameters:
- ILLEGAL_HALT, 1: 1 = the ERROR state is sticky until reset; 0 = ERROR returns to FETCH on the next cycle.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- op  in  7  instruction[6:0]
- funct3  in  3  instruction[14:12]
- funct7b5  in  1  instruction[30]
- Zero  in  1  ALU zero flag
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result register
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction register enable
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = read data, 10 = ALU result
- ALUSrcA  out  2  A operand select: 00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  B operand select: 00 = rs2, 01 = immediate, 10 = constant 4
- ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- RegWrite  out  1  register file write enable
- ALUControl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt
- InstrDone  out  1  one-cycle pulse on the last cycle of each instruction
- Illegal  out  1  high while the FSM is in ERROR
- State  out  4  current state code, for debug

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high. A clk edge with reset=1 loads FETCH.
- While reset=1, PCWrite, MemWrite, IRWrite, RegWrite and InstrDone are forced to 0; all other outputs follow the FETCH decode.
- Outputs are combinational from the state register (Moore). The only exceptions are PCWrite (depends on Zero) and ALUControl/ImmSrc (depend on instruction fields).
- Any output not listed for a state is 0.
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10, ERROR=11.
- Per-state outputs:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target).
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
  - ERROR: all enables 0.
- PCWrite = PCUpdate | (Branch & TakeBranch), where TakeBranch = Zero for beq.
- Transitions:
  - FETCH -> DECODE.
  - DECODE on op: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1101111 -> JAL; 1100011 -> BEQ; any other op -> ERROR.
  - Branch op with funct3 not accepted (see Optional Feature) -> ERROR.
  - MEMADR: op[5]=0 -> MEMREAD, op[5]=1 -> MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH.
  - EXECR, EXECI, JAL -> ALUWB -> FETCH.
  - MEMWRITE -> FETCH; BEQ -> FETCH.
  - ERROR -> ERROR if ILLEGAL_HALT=1, else -> FETCH.
- Cycles per instruction: lw 5; sw, R-type, I-type, jal 4; beq 3.
- InstrDone is high in MEMWB, MEMWRITE, ALUWB and BEQ.
- ALU decoder:
  - ALUOp 00 -> 000; ALUOp 01 -> 001.
  - ALUOp 10, by funct3: 000 -> 001 if {op[5],funct7b5}=11, else 000; 010 -> 101; 110 -> 011; 111 -> 010; others -> 000.
- ImmSrc from op: I-type/lw 00, sw 01, branch 10, jal 11, others 00.
- Reset mid-instruction: the next edge goes to FETCH; no write enable is asserted during reset.

Optional Feature:
- Macro: BNE_EN.
- Defined: branch funct3=001 (bne) is legal; TakeBranch = ~Zero for bne, Zero for beq (000); any other branch funct3 -> ERROR.
- Undefined: only branch funct3=000 is legal; 001 -> ERROR.

Test Plan:
- Reset held 2 cycles with an arbitrary prior state -> State=0, PCWrite=IRWrite=RegWrite=MemWrite=0 during reset; after release, IRWrite=1 and PCWrite=1 in the first cycle.
- add (op=0110011, funct3=000, funct7b5=0) -> states 0,1,6,7,0; ALUControl=000 in EXECR; RegWrite=1 only in ALUWB; InstrDone pulses once.
- sub (funct7b5=1) then addi with funct7b5=1 (op=0010011) -> ALUControl=001 for sub, 000 for addi.
- lw (op=0000011) -> states 0,1,2,3,4, 5 cycles; AdrSrc=1 in MEMREAD; ResultSrc=01 and RegWrite=1 in MEMWB.
- beq with Zero=1, then beq with Zero=0 -> PCWrite=1 in BEQ only for the first; ALUControl=001; 3 cycles each.
- op=1111111 -> ERROR, Illegal=1: held with ILLEGAL_HALT=1, one cycle then FETCH with ILLEGAL_HALT=0.
- bne (funct3=001): with BNE_EN and Zero=0 -> PCWrite=1; without BNE_EN -> ERROR.

Source files
------------

// File: rtl/riscv_mc_controller.sv
// riscv_mc_controller: multicycle RV32 control unit (lw, sw, R-type, I-type ALU, beq, jal).
// A Moore FSM sequences each instruction. It drives the datapath selects and write
// enables, and decodes the 3-bit ALUControl for the ALU.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   op, funct3, funct7b5 instruction fields; Zero is the ALU zero flag
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
//   RegWrite, ALUControl  datapath controls
//   InstrDone           pulse on the last cycle of each instruction
//   Illegal             high in ERROR
//   State               current state code (debug)
// Parameter ILLEGAL_HALT: 1 = ERROR is sticky until reset, 0 = ERROR returns to FETCH.
// Macro BNE_EN: when defined, branch funct3=001 (bne) is legal.
module riscv_mc_controller #(
    parameter int unsigned ILLEGAL_HALT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic [2:0] ALUControl,
    output logic       InstrDone,
    output logic       Illegal,
    output logic [3:0] State
);
    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_ERROR    = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    state_t     state, next_state, cur;
    logic [1:0] alu_op;
    logic       pc_update, branch, take_branch, branch_ok;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    // While reset is held the outputs decode as FETCH
    assign cur   = reset ? S_FETCH : state;
    assign State = cur;

`ifdef BNE_EN
    assign branch_ok   = (funct3 == 3'b000) || (funct3 == 3'b001);
    assign take_branch = (funct3 == 3'b001) ? ~Zero : Zero;
`else
    assign branch_ok   = (funct3 == 3'b000);
    assign take_branch = Zero;
`endif

    // Next-state and per-state Moore outputs
    always_comb begin
        next_state = S_FETCH;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        RegWrite   = 1'b0;
        alu_op     = 2'b00;
        pc_update  = 1'b0;
        branch     = 1'b0;
        InstrDone  = 1'b0;
        Illegal    = 1'b0;
        unique case (cur)
            S_FETCH: begin
                IRWrite    = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                pc_update  = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                unique case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXECR;
                    OP_ITYPE:     next_state = S_EXECI;
                    OP_JAL:       next_state = S_JAL;
                    OP_BR:        next_state = branch_ok ? S_BEQ : S_ERROR;
                    default:      next_state = S_ERROR;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc     = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                MemWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                alu_op     = 2'b10;
                next_state = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                alu_op     = 2'b10;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            S_JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pc_update  = 1'b1;
                next_state = S_ALUWB;
            end
            S_BEQ: begin
                ALUSrcA   = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
                InstrDone = 1'b1;
            end
            S_ERROR: begin
                Illegal    = 1'b1;
                next_state = (ILLEGAL_HALT != 0) ? S_ERROR : S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase
        // No write enable may fire while reset is asserted
        PCWrite = ~reset & (pc_update | (branch & take_branch));
        if (reset) begin
            MemWrite  = 1'b0;
            IRWrite   = 1'b0;
            RegWrite  = 1'b0;
            InstrDone = 1'b0;
        end
    end

    // ALU decoder
    always_comb begin
        ALUControl = 3'b000;
        unique case (alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                unique case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    // Immediate format follows the opcode directly
    always_comb begin
        ImmSrc = 2'b00;
        unique case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BR:   ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end
endmodule

// File: tb/tb_riscv_mc_controller.sv
// Directed bench for riscv_mc_controller; dut uses ILLEGAL_HALT=1, dut2 uses ILLEGAL_HALT=0.
module tb_riscv_mc_controller;
    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, Zero;

    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, InstrDone, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;

    logic       PCWrite2, AdrSrc2, MemWrite2, IRWrite2, RegWrite2, InstrDone2, Illegal2;
    logic [1:0] ResultSrc2, ALUSrcA2, ALUSrcB2, ImmSrc2;
    logic [2:0] ALUControl2;
    logic [3:0] State2;

    int checks = 0;
    int errors = 0;

    riscv_mc_controller #(.ILLEGAL_HALT(1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .RegWrite(RegWrite), .ALUControl(ALUControl), .InstrDone(InstrDone),
        .Illegal(Illegal), .State(State)
    );

    riscv_mc_controller #(.ILLEGAL_HALT(0)) dut2 (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
        .PCWrite(PCWrite2), .AdrSrc(AdrSrc2), .MemWrite(MemWrite2), .IRWrite(IRWrite2),
        .ResultSrc(ResultSrc2), .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2), .ImmSrc(ImmSrc2),
        .RegWrite(RegWrite2), .ALUControl(ALUControl2), .InstrDone(InstrDone2),
        .Illegal(Illegal2), .State(State2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
        tick(); tick();
        checks++; if (State !== 4'd6) begin errors++; $display("FAIL pre_reset_state got %0d exp 6", State); end
        reset = 1'b1; #1;
        checks++;
        if ({PCWrite, IRWrite, RegWrite, MemWrite, InstrDone} !== 5'b0 || ALUSrcB !== 2'b10) begin
            errors++; $display("FAIL reset_comb en=%b srcb=%b exp en=00000 srcb=10",
                               {PCWrite, IRWrite, RegWrite, MemWrite, InstrDone}, ALUSrcB);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (State !== 4'd0 || {PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0) begin
                errors++; $display("FAIL reset_hold cyc%0d state=%0d en=%b exp state=0 en=0000",
                                   c, State, {PCWrite, IRWrite, RegWrite, MemWrite});
            end
        end
        reset = 1'b0; #1;
        checks++;
        if (State !== 4'd0 || IRWrite !== 1'b1 || PCWrite !== 1'b1) begin
            errors++; $display("FAIL reset_release state=%0d ir=%b pc=%b exp 0 1 1", State, IRWrite, PCWrite);
        end
    endtask

    task automatic test_add();
        logic [3:0] exp_st[4] = '{4'd0, 4'd1, 4'd6, 4'd7};
        int done_cnt = 0;
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (State !== exp_st[i] || RegWrite !== (i == 3)) begin
                errors++; $display("FAIL add_seq cyc%0d state=%0d rw=%b exp state=%0d rw=%b",
                                   i, State, RegWrite, exp_st[i], (i == 3));
            end
            if (i == 2) begin
                checks++;
                if (ALUControl !== 3'b000) begin errors++; $display("FAIL add_aluctl got %b exp 000", ALUControl); end
            end
            if (InstrDone === 1'b1) done_cnt++;
            tick();
        end
        checks++;
        if (State !== 4'd0 || done_cnt != 1) begin
            errors++; $display("FAIL add_end state=%0d done=%0d exp 0 1", State, done_cnt);
        end
    endtask

    task automatic test_sub_addi();
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
        tick(); tick();
        checks++;
        if (State !== 4'd6 || ALUControl !== 3'b001) begin
            errors++; $display("FAIL sub_aluctl state=%0d ctl=%b exp 6 001", State, ALUControl);
        end
        tick(); tick();
        op = 7'b0010011;
        tick(); tick();
        checks++;
        if (State !== 4'd8 || ALUControl !== 3'b000 || ALUSrcB !== 2'b01 || ImmSrc !== 2'b00) begin
            errors++; $display("FAIL addi_exec state=%0d ctl=%b srcb=%b imm=%b exp 8 000 01 00",
                               State, ALUControl, ALUSrcB, ImmSrc);
        end
        tick();
        checks++;
        if (State !== 4'd7 || RegWrite !== 1'b1) begin
            errors++; $display("FAIL addi_wb state=%0d rw=%b exp 7 1", State, RegWrite);
        end
        tick();
        funct3 = 3'b110; funct7b5 = 1'b0; op = 7'b0110011;
        tick(); tick();
        checks++;
        if (ALUControl !== 3'b011) begin errors++; $display("FAIL or_aluctl got %b exp 011", ALUControl); end
        tick(); tick();
    endtask

    task automatic test_mem();
        logic [3:0] exp_lw[5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (State !== exp_lw[i]) begin
                errors++; $display("FAIL lw_seq cyc%0d state=%0d exp %0d", i, State, exp_lw[i]);
            end
            if (i == 3) begin
                checks++;
                if (AdrSrc !== 1'b1 || ResultSrc !== 2'b00) begin
                    errors++; $display("FAIL lw_memread adr=%b res=%b exp 1 00", AdrSrc, ResultSrc);
                end
            end
            if (i == 4) begin
                checks++;
                if (ResultSrc !== 2'b01 || RegWrite !== 1'b1 || InstrDone !== 1'b1) begin
                    errors++; $display("FAIL lw_memwb res=%b rw=%b done=%b exp 01 1 1", ResultSrc, RegWrite, InstrDone);
                end
            end
            tick();
        end
        checks++; if (State !== 4'd0) begin errors++; $display("FAIL lw_end state=%0d exp 0", State); end
        op = 7'b0100011;
        tick(); tick(); tick();
        checks++;
        if (State !== 4'd5 || MemWrite !== 1'b1 || AdrSrc !== 1'b1 || ImmSrc !== 2'b01 || RegWrite !== 1'b0) begin
            errors++; $display("FAIL sw_memwrite state=%0d mw=%b adr=%b imm=%b rw=%b exp 5 1 1 01 0",
                               State, MemWrite, AdrSrc, ImmSrc, RegWrite);
        end
        tick();
        checks++; if (State !== 4'd0) begin errors++; $display("FAIL sw_end state=%0d exp 0", State); end
    endtask

    task automatic test_beq();
        op = 7'b1100011; funct3 = 3'b000; Zero = 1'b1;
        tick();
        checks++;
        if (State !== 4'd1 || PCWrite !== 1'b0) begin
            errors++; $display("FAIL beq_decode state=%0d pc=%b exp 1 0", State, PCWrite);
        end
        tick();
        checks++;
        if (State !== 4'd10 || PCWrite !== 1'b1 || ALUControl !== 3'b001 || ImmSrc !== 2'b10) begin
            errors++; $display("FAIL beq_taken state=%0d pc=%b ctl=%b imm=%b exp 10 1 001 10",
                               State, PCWrite, ALUControl, ImmSrc);
        end
        tick();
        checks++; if (State !== 4'd0) begin errors++; $display("FAIL beq_taken_end state=%0d exp 0", State); end
        Zero = 1'b0;
        tick(); tick();
        checks++;
        if (State !== 4'd10 || PCWrite !== 1'b0 || InstrDone !== 1'b1) begin
            errors++; $display("FAIL beq_not_taken state=%0d pc=%b done=%b exp 10 0 1", State, PCWrite, InstrDone);
        end
        tick();
        checks++; if (State !== 4'd0) begin errors++; $display("FAIL beq_nt_end state=%0d exp 0", State); end
    endtask

    task automatic test_jal();
        op = 7'b1101111; funct3 = 3'b000;
        tick(); tick();
        checks++;
        if (State !== 4'd9 || PCWrite !== 1'b1 || ALUSrcA !== 2'b01 || ALUSrcB !== 2'b10 || ImmSrc !== 2'b11) begin
            errors++; $display("FAIL jal_state state=%0d pc=%b a=%b b=%b imm=%b exp 9 1 01 10 11",
                               State, PCWrite, ALUSrcA, ALUSrcB, ImmSrc);
        end
        tick();
        checks++;
        if (State !== 4'd7 || RegWrite !== 1'b1) begin errors++; $display("FAIL jal_wb state=%0d rw=%b exp 7 1", State, RegWrite); end
        tick();
    endtask

    task automatic test_bne();
        op = 7'b1100011; funct3 = 3'b001; Zero = 1'b0;
        tick(); tick();
`ifdef BNE_EN
        checks++;
        if (State !== 4'd10 || PCWrite !== 1'b1) begin
            errors++; $display("FAIL bne_taken state=%0d pc=%b exp 10 1", State, PCWrite);
        end
        tick();
`else
        checks++;
        if (State !== 4'd11 || Illegal !== 1'b1 || PCWrite !== 1'b0) begin
            errors++; $display("FAIL bne_illegal state=%0d ill=%b pc=%b exp 11 1 0", State, Illegal, PCWrite);
        end
        reset = 1'b1; tick(); reset = 1'b0; #1;
`endif
        checks++; if (State !== 4'd0) begin errors++; $display("FAIL bne_end state=%0d exp 0", State); end
    endtask

    task automatic test_illegal();
        op = 7'b1111111; funct3 = 3'b000;
        tick(); tick();
        checks++;
        if (State !== 4'd11 || Illegal !== 1'b1 || State2 !== 4'd11 || Illegal2 !== 1'b1) begin
            errors++; $display("FAIL illegal_enter st=%0d ill=%b st2=%0d ill2=%b exp 11 1 11 1",
                               State, Illegal, State2, Illegal2);
        end
        checks++;
        if ({PCWrite, IRWrite, RegWrite, MemWrite, InstrDone} !== 5'b0) begin
            errors++; $display("FAIL illegal_en got %b exp 00000", {PCWrite, IRWrite, RegWrite, MemWrite, InstrDone});
        end
        tick();
        checks++;
        if (State !== 4'd11 || Illegal !== 1'b1 || State2 !== 4'd0 || Illegal2 !== 1'b0) begin
            errors++; $display("FAIL illegal_next st=%0d ill=%b st2=%0d ill2=%b exp 11 1 0 0",
                               State, Illegal, State2, Illegal2);
        end
        tick(); tick();
        checks++; if (State !== 4'd11) begin errors++; $display("FAIL illegal_sticky state=%0d exp 11", State); end
        reset = 1'b1; tick(); reset = 1'b0; #1;
        checks++;
        if (State !== 4'd0 || Illegal !== 1'b0) begin
            errors++; $display("FAIL illegal_recover state=%0d ill=%b exp 0 0", State, Illegal);
        end
    endtask

    initial begin
        reset = 1'b1; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; Zero = 1'b0;
        tick(); tick();
        test_reset();
        test_add();
        test_sub_addi();
        test_mem();
        test_beq();
        test_jal();
        test_bne();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
